// File: rtl/sa_cache_pkg.sv
// Shared types for the 4-way set-associative cache: way index, way count and
// the allocation controller state encoding.
package sa_cache_pkg;

    typedef logic [1:0] way_t;

    localparam int unsigned NUM_WAYS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RF,
        FILL,
        RESP
    } alloc_state_t;

endpackage

// File: rtl/sa_victim_pick.sv
// Combinational victim selection. With SA_ALLOC_INVALID_FIRST_EN defined the
// lowest-index invalid way wins; otherwise the LRU victim is always used.
module sa_victim_pick
    import sa_cache_pkg::*;
(
    input  logic [NUM_WAYS-1:0] valid_bits,
    input  way_t                lru_way,
    output way_t                victim
);

`ifdef SA_ALLOC_INVALID_FIRST_EN
    always_comb begin
        victim = lru_way;
        // Descending scan so the lowest invalid index is the last write.
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_bits[i]) begin
                victim = way_t'(i);
            end
        end
    end
`else
    logic unused_valid;
    assign unused_valid = ^valid_bits;
    assign victim       = lru_way;
`endif

endmodule

// File: rtl/sa_way_alloc.sv
// Miss-handling and way-allocation controller: victim pick, writeback, refill,
// fill commit and LRU touch. Optional feature macro: SA_ALLOC_INVALID_FIRST_EN.
module sa_way_alloc
    import sa_cache_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                hit,
    input  way_t                hit_way,
    input  logic [NUM_WAYS-1:0] valid_bits,
    input  logic [NUM_WAYS-1:0] dirty_bits,
    input  way_t                lru_way,
    output logic                touch_we,
    output way_t                touch_way,
    output logic                wb_req,
    input  logic                wb_ack,
    output logic                rf_req,
    input  logic                rf_ack,
    output logic                fill_we,
    output way_t                victim_way,
    output logic                done,
    output logic                err
);

    localparam int unsigned  CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit           TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES) - CNT_W'(1);

    alloc_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    way_t             victim_q, victim_d;
    way_t             hit_way_q, hit_way_d;
    logic             hit_pend_q, hit_pend_d;
    logic             err_q, err_d;
    way_t             pick;
    logic             timeout;

    sa_victim_pick u_pick (
        .valid_bits (valid_bits),
        .lru_way    (lru_way),
        .victim     (pick)
    );

    // Saturating count; timeout fires on the edge that would make it TIMEOUT_CYCLES.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        victim_d   = victim_q;
        hit_way_d  = hit_way_q;
        hit_pend_d = hit_pend_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (hit) begin
                        hit_way_d  = hit_way;
                        hit_pend_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        victim_d = pick;
                        cnt_d    = '0;
                        state_d  = (valid_bits[pick] && dirty_bits[pick]) ? WB : RF;
                    end
                end
            end
            WB: begin
                if (wb_ack) begin
                    cnt_d   = '0;
                    state_d = RF;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RF: begin
                if (rf_ack) begin
                    state_d = FILL;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            FILL: state_d = RESP;
            RESP: begin
                // A hit spends one RESP cycle touching before the done cycle.
                if (hit_pend_q) begin
                    hit_pend_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            victim_q   <= '0;
            hit_way_q  <= '0;
            hit_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            victim_q   <= victim_d;
            hit_way_q  <= hit_way_d;
            hit_pend_q <= hit_pend_d;
            err_q      <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign wb_req     = (state_q == WB);
    assign rf_req     = (state_q == RF);
    assign fill_we    = (state_q == FILL);
    assign touch_we   = (state_q == FILL) || ((state_q == RESP) && hit_pend_q);
    assign touch_way  = (state_q == FILL) ? victim_q :
                        ((state_q == RESP) && hit_pend_q) ? hit_way_q : '0;
    assign done       = (state_q == RESP) && !hit_pend_q;
    assign err        = err_q;
    assign victim_way = victim_q;

endmodule

// File: tb/tb_sa_way_alloc.sv
// Directed self-checking bench for sa_way_alloc (TIMEOUT_CYCLES=8).
module tb_sa_way_alloc;
    import sa_cache_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       req_valid, req_ready, hit;
    logic [1:0] hit_way, lru_way, touch_way, victim_way;
    logic [3:0] valid_bits, dirty_bits;
    logic       touch_we, wb_req, wb_ack, rf_req, rf_ack, fill_we, done, err;

    always #5 CLK = ~CLK;

    sa_way_alloc #(.TIMEOUT_CYCLES(8)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .hit        (hit),
        .hit_way    (hit_way),
        .valid_bits (valid_bits),
        .dirty_bits (dirty_bits),
        .lru_way    (lru_way),
        .touch_we   (touch_we),
        .touch_way  (touch_way),
        .wb_req     (wb_req),
        .wb_ack     (wb_ack),
        .rf_req     (rf_req),
        .rf_ack     (rf_ack),
        .fill_we    (fill_we),
        .victim_way (victim_way),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic       hit;
        logic [1:0] hit_way;
        logic [3:0] valid;
        logic [3:0] dirty;
        logic [1:0] lru;
        int         wb_dly;
        int         rf_dly;
        logic [1:0] exp_victim;
        logic       exp_wb;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        chk("ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        hit        = v.hit;
        hit_way    = v.hit_way;
        valid_bits = v.valid;
        dirty_bits = v.dirty;
        lru_way    = v.lru;
        step();
        req_valid = 1'b0;
        if (v.hit) begin
            chk("hit_touch_we", touch_we, 1);
            chk("hit_touch_way", touch_way, v.hit_way);
            chk("hit_done_early", done, 0);
            chk("hit_busy", req_ready, 0);
            step();
            chk("hit_done", done, 1);
            chk("hit_touch_off", touch_we, 0);
            step();
            chk("hit_done_off", done, 0);
            chk("hit_ready", req_ready, 1);
        end else begin
            chk("miss_victim", victim_way, v.exp_victim);
            chk("miss_wb_req", wb_req, v.exp_wb);
            chk("miss_rf_req", rf_req, !v.exp_wb);
            if (v.exp_wb) begin
                for (int i = 0; i < v.wb_dly; i++) begin
                    step();
                    chk("wb_hold", wb_req, 1);
                end
                wb_ack = 1'b1;
                step();
                wb_ack = 1'b0;
                chk("wb_drop", wb_req, 0);
                chk("rf_after_wb", rf_req, 1);
                chk("victim_stable", victim_way, v.exp_victim);
            end
            for (int i = 0; i < v.rf_dly; i++) begin
                step();
                chk("rf_hold", rf_req, 1);
            end
            rf_ack = 1'b1;
            step();
            rf_ack = 1'b0;
            chk("rf_drop", rf_req, 0);
            chk("fill_we", fill_we, 1);
            chk("fill_touch_we", touch_we, 1);
            chk("fill_touch_way", touch_way, v.exp_victim);
            chk("fill_done_early", done, 0);
            step();
            chk("miss_done", done, 1);
            chk("fill_we_off", fill_we, 0);
            chk("resp_touch_off", touch_we, 0);
            chk("victim_at_done", victim_way, v.exp_victim);
            chk("no_err", err, 0);
            step();
            chk("miss_ready", req_ready, 1);
            chk("miss_done_off", done, 0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd2, 4'hF, 4'h0, 2'd0, 0, 0, 2'd2, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 4'hF, 4'h0, 2'd3, 0, 0, 2'd0, 1'b0};
        vecs[2] = '{1'b0, 2'd0, 4'hF, 4'b0001, 2'd0, 3, 2, 2'd0, 1'b1};
`ifdef SA_ALLOC_INVALID_FIRST_EN
        vecs[3] = '{1'b0, 2'd0, 4'b1011, 4'b0001, 2'd0, 1, 1, 2'd2, 1'b0};
        vecs[6] = '{1'b0, 2'd0, 4'b0000, 4'hF, 2'd2, 0, 0, 2'd0, 1'b0};
`else
        vecs[3] = '{1'b0, 2'd0, 4'b1011, 4'b0001, 2'd0, 1, 1, 2'd0, 1'b1};
        vecs[6] = '{1'b0, 2'd0, 4'b0000, 4'hF, 2'd2, 0, 0, 2'd2, 1'b0};
`endif
        vecs[4] = '{1'b0, 2'd0, 4'hF, 4'b0100, 2'd1, 0, 0, 2'd1, 1'b0};
        vecs[5] = '{1'b0, 2'd0, 4'b0111, 4'hF, 2'd3, 0, 1, 2'd3, 1'b0};

        RST_N = 1'b0; req_valid = 1'b0; hit = 1'b0; hit_way = '0;
        valid_bits = '0; dirty_bits = '0; lru_way = '0; wb_ack = 1'b0; rf_ack = 1'b0;
        step();
        step();
        chk("rst_ready", req_ready, 1);
        chk("rst_victim", victim_way, 0);
        chk("rst_outs", {touch_we, touch_way, wb_req, rf_req, fill_we, done, err}, 0);
        RST_N = 1'b1;
        step();

        for (int k = 0; k < 7; k++) run_txn(vecs[k]);

        // Timeout in RF; a stray wb_ack during RF must be ignored.
        req_valid = 1'b1; hit = 1'b0; valid_bits = 4'hF; dirty_bits = 4'h0; lru_way = 2'd1;
        step();
        req_valid = 1'b0;
        wb_ack    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("to_rf_hold", rf_req, 1);
            chk("to_err_early", err, 0);
            step();
        end
        wb_ack = 1'b0;
        chk("to_err", err, 1);
        chk("to_rf_drop", rf_req, 0);
        chk("to_idle", req_ready, 1);
        chk("to_no_touch", touch_we, 0);
        chk("to_no_done", done, 0);
        step();
        chk("to_err_pulse", err, 0);
        chk("to_no_done2", done, 0);

        // Reset mid-WB aborts silently; a later wb_ack is ignored.
        req_valid = 1'b1; valid_bits = 4'hF; dirty_bits = 4'b1000; lru_way = 2'd3;
        step();
        req_valid = 1'b0;
        chk("rwb_victim", victim_way, 3);
        chk("rwb_wb_req", wb_req, 1);
        step();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        chk("rwb_ready", req_ready, 1);
        chk("rwb_victim_rst", victim_way, 0);
        chk("rwb_outs", {touch_we, touch_way, wb_req, rf_req, fill_we, done, err}, 0);
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        chk("rwb_ack_ign", {wb_req, rf_req, done, err}, 0);
        chk("rwb_ready2", req_ready, 1);

        // req_valid held through a miss: no re-acceptance while busy.
        req_valid = 1'b1; valid_bits = 4'hF; dirty_bits = 4'h0; lru_way = 2'd2;
        step();
        hit = 1'b1; hit_way = 2'd1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_rf", rf_req, 1);
            chk("hold_busy", req_ready, 0);
            step();
        end
        rf_ack = 1'b1;
        step();
        rf_ack = 1'b0;
        chk("hold_fill", fill_we, 1);
        chk("hold_fill_way", touch_way, 2);
        step();
        chk("hold_done", done, 1);
        chk("hold_done_busy", req_ready, 0);
        step();
        req_valid = 1'b0;
        chk("hold_ready", req_ready, 1);
        chk("hold_no_touch", touch_we, 0);
        step();
        chk("hold_idle", req_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
